page_fetch_arbiter: RTL and testbench
=====================================

PAGE_FETCH_ARBITER -- requirements
Module: page_fetch_arbiter

Interface
REQ-001 SHALL have parameter Y_W, 10, width of the line index carried in the tag.
REQ-002 SHALL have parameter LINE_SHIFT, 9, log2 of the words per line page; page address = line << LINE_SHIFT.
REQ-003 SHALL have parameter ADDR_W, 24, SDRAM word-address width.
REQ-004 SHALL have parameter DEPTH_LOG2, 2, log2 of the pending page-request FIFO depth (4 entries).
REQ-005 SHALL have port iClock  in  1  main clock; all state updates on its rising edge.
REQ-006 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port iTag  in  Y_W+1  VGA-domain tag; [Y_W] = buffer-low warning, [Y_W-1:0] = line to fetch; asynchronous to iClock.
REQ-008 SHALL have port iCall  in  2  user request, [1] write, [0] read; held high until the matching oDone.
REQ-009 SHALL have port oDone  out  2  user completion pulses, [1] write, [0] read.
REQ-010 SHALL have port oCall  out  3  SDRAM controller request, [2] page read, [1] write, [0] read; one-hot or zero.
REQ-011 SHALL have port iDone  in  3  SDRAM controller completion pulses, same bit mapping as oCall.
REQ-012 SHALL have port oAddrPage  out  ADDR_W  page start address for the page read.
REQ-013 SHALL have port oOverflow  out  1  sticky flag: a page request was dropped.
REQ-014 SHALL have port oBusy  out  1  high whenever the state machine is not IDLE.

Function
REQ-015 SHALL pass iTag through a two-stage register synchroniser (F1 then F2) before any use.
REQ-016 SHALL detect a request when F2[Y_W]==0 and F1[Y_W]==1 and push F1[Y_W-1:0] into the FIFO that cycle.
REQ-017 SHALL drop a push when the FIFO is full and not popped in the same cycle, and set oOverflow to 1 until reset.
REQ-018 SHALL accept the push when full and a pop occur in the same cycle; occupancy unchanged, no overflow.
REQ-019 SHALL implement states IDLE, GFETCH, USER; reset state IDLE.
REQ-020 SHALL, in IDLE with FIFO non-empty, enter GFETCH next cycle with oCall=3'b100 and oAddrPage = FIFO head << LINE_SHIFT, zero-extended and truncated to ADDR_W.
REQ-021 SHALL, in IDLE with FIFO empty and iCall!=0, enter USER with oCall={1'b0,iCall[1],iCall[0]&~iCall[1]} (write wins when both set).
REQ-022 SHALL give page reads priority over user calls only at the IDLE decision; a USER transaction is never pre-empted.
REQ-023 SHALL hold oCall and oAddrPage constant while in GFETCH or USER.
REQ-024 SHALL, on iDone[2] in GFETCH, pop the FIFO, clear oCall, and return to IDLE on the next edge.
REQ-025 SHALL, on iDone[1] or iDone[0] in USER, clear oCall, return to IDLE on the next edge, and drive oDone = iDone[1:0] combinationally that cycle.
REQ-026 SHALL hold oDone at 2'b00 outside USER and ignore iDone bits not matching the active oCall bit.
REQ-027 SHALL wrap FIFO read and write pointers modulo 2^DEPTH_LOG2 and track occupancy with a DEPTH_LOG2+1-bit count.
REQ-028 SHALL spend at least one IDLE cycle between consecutive transactions.

Reset
REQ-029 SHALL, on RESET low, asynchronously clear F1, F2, FIFO pointers and count, state (IDLE), oCall, oAddrPage, oOverflow, and the drop counter if present.
REQ-030 SHALL, on reset mid-transaction, deassert oCall immediately and discard queued page requests.

Configuration
REQ-031 SHALL, with macro PAGE_FETCH_DROPCNT_EN defined, add port oDropCnt  out  8  saturating count of dropped page requests, holding at 255.
REQ-032 SHALL, without PAGE_FETCH_DROPCNT_EN, omit oDropCnt and its register; all other behaviour is identical.

Verification
REQ-033 SHALL cover: tag MSB 0->1 with line 10'd37 -> within 4 cycles oCall=3'b100 and oAddrPage=24'h004A00; iDone[2] pulse -> oCall=0, FIFO empty.
REQ-034 SHALL cover: iCall=2'b11 with FIFO empty -> oCall=3'b010; iDone[1] -> oDone=2'b10 for one cycle, then IDLE.
REQ-035 SHALL cover: tag edge during USER write -> write finishes first, page read issued right after the IDLE cycle.
REQ-036 SHALL cover: 5 tag edges with iDone held low -> 4 entries queued, oOverflow=1, oDropCnt=1 with the macro defined.
REQ-037 SHALL cover: FIFO full, iDone[2] coincident with a new tag edge -> no overflow, count stays 4.
REQ-038 SHALL cover: RESET low during GFETCH -> oCall=0 in the same cycle, oBusy=0, queued entries lost.

Source files
------------

// File: rtl/page_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// page_fetch_arbiter
//
// Arbitrates access to a single-port SDRAM controller between two clients:
// - Page reads requested from the VGA domain. A rising edge on the tag's
//   buffer-low bit queues the tagged line index in a small FIFO.
// - User reads and writes, requested with a level handshake.
// Page reads win only at the IDLE decision point. A transaction that is
// already running is never pre-empted.
//
// Optional feature: define PAGE_FETCH_DROPCNT_EN to add oDropCnt. This is a
// saturating 8-bit count of page requests dropped because the FIFO was full.
//
// Ports
//   iClock     in   1        main clock, rising-edge active
//   RESET      in   1        asynchronous, active-low reset
//   iTag       in   Y_W+1    VGA-domain tag: [Y_W] buffer-low, [Y_W-1:0] line
//   iCall      in   2        user request, [1] write, [0] read (held to oDone)
//   oDone      out  2        user completion pulses, [1] write, [0] read
//   oCall      out  3        SDRAM request, [2] page read, [1] write, [0] read
//   iDone      in   3        SDRAM completion pulses, same mapping as oCall
//   oAddrPage  out  ADDR_W   start word address of the page being read
//   oOverflow  out  1        sticky: a page request was dropped
//   oBusy      out  1        state machine is not IDLE
//   oDropCnt   out  8        (PAGE_FETCH_DROPCNT_EN only) dropped-request count
// ---------------------------------------------------------------------------
module page_fetch_arbiter #(
    parameter int Y_W        = 10,
    parameter int LINE_SHIFT = 9,
    parameter int ADDR_W     = 24,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              iClock,
    input  logic              RESET,
    input  logic [Y_W:0]      iTag,
    input  logic [1:0]        iCall,
    output logic [1:0]        oDone,
    output logic [2:0]        oCall,
    input  logic [2:0]        iDone,
    output logic [ADDR_W-1:0] oAddrPage,
    output logic              oOverflow,
`ifdef PAGE_FETCH_DROPCNT_EN
    output logic [7:0]        oDropCnt,
`endif
    output logic              oBusy
);

    localparam int                CNT_W    = DEPTH_LOG2 + 1;
    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, GFETCH, USER} stateType;

    stateType                state, nextState;
    logic [2:0]              nextCall;
    logic [ADDR_W-1:0]       nextAddr;

    // Tag synchroniser. Only the warning bit of the second stage is ever
    // consumed, so that stage keeps just that bit.
    logic [Y_W:0]            syncF1;
    logic                    syncF2Warn;

    logic [Y_W-1:0]          fifoMem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wrPtr, rdPtr;
    logic [CNT_W-1:0]        fifoCount;

    logic                    tagRise, fifoFull, popReq, pushOk, pushDrop;
    logic [ADDR_W+Y_W-1:0]   headWide;

    assign tagRise  = syncF1[Y_W] & ~syncF2Warn;
    assign fifoFull = (fifoCount == FULL_CNT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pushOk   = tagRise & (~fifoFull | popReq);
    assign pushDrop = tagRise & fifoFull & ~popReq;
    assign headWide = (ADDR_W+Y_W)'(fifoMem[rdPtr]) << LINE_SHIFT;
    assign oBusy    = (state != IDLE);

    always_ff @(posedge iClock or negedge RESET) begin
        // NOTE: all sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block ordering.
        if (!RESET) begin
            syncF1     <= '0;
            syncF2Warn <= 1'b0;
        end else begin
            syncF1     <= iTag;
            syncF2Warn <= syncF1[Y_W];
        end
    end

    // NOTE: the FIFO storage has no reset. The pointers and count define
    // which entries are valid, and resetting the array would only add logic.
    always_ff @(posedge iClock) begin
        if (pushOk) begin
            fifoMem[wrPtr] <= syncF1[Y_W-1:0];
        end
    end

    always_ff @(posedge iClock or negedge RESET) begin
        if (!RESET) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (popReq) rdPtr <= rdPtr + 1'b1;
            case ({pushOk, popReq})
                2'b10:   fifoCount <= fifoCount + CNT_ONE;
                2'b01:   fifoCount <= fifoCount - CNT_ONE;
                default: fifoCount <= fifoCount;
            endcase
            if (pushDrop) oOverflow <= 1'b1;
        end
    end

`ifdef PAGE_FETCH_DROPCNT_EN
    always_ff @(posedge iClock or negedge RESET) begin
        if (!RESET) begin
            oDropCnt <= 8'd0;
        end else if (pushDrop && (oDropCnt != 8'hFF)) begin
            oDropCnt <= oDropCnt + 8'd1;
        end
    end
`endif

    // State, request and address registers. oCall is registered so that it
    // stays constant for the whole transaction.
    always_ff @(posedge iClock or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            oCall     <= 3'b000;
            oAddrPage <= '0;
        end else begin
            state     <= nextState;
            oCall     <= nextCall;
            oAddrPage <= nextAddr;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // leaves one unassigned would infer a latch.
        nextState = state;
        nextCall  = oCall;
        nextAddr  = oAddrPage;
        popReq    = 1'b0;
        oDone     = 2'b00;
        case (state)
            IDLE: begin
                if (fifoCount != '0) begin
                    nextState = GFETCH;
                    nextCall  = 3'b100;
                    nextAddr  = headWide[ADDR_W-1:0];
                end else if (iCall != 2'b00) begin
                    nextState = USER;
                    // Write wins when both request bits are set.
                    nextCall  = {1'b0, iCall[1], iCall[0] & ~iCall[1]};
                end
            end
            GFETCH: begin
                if (iDone[2]) begin
                    popReq    = 1'b1;
                    nextState = IDLE;
                    nextCall  = 3'b000;
                end
            end
            USER: begin
                // Only the completion bit of the active request counts.
                oDone = iDone[1:0] & oCall[1:0];
                if (oDone != 2'b00) begin
                    nextState = IDLE;
                    nextCall  = 3'b000;
                end
            end
            default: begin
                nextState = IDLE;
                nextCall  = 3'b000;
            end
        endcase
    end

endmodule

// File: tb/tb_page_fetch_arbiter.sv
// ---------------------------------------------------------------------------
// tb_page_fetch_arbiter
//
// Self-checking bench for page_fetch_arbiter.
// - Directed scenarios pin the model with hand-computed literal values.
// - A randomized phase follows.
// - A queue-based behavioural model tracks the expected outputs. A compare
//   process checks them on every falling clock edge.
// Define PAGE_FETCH_DROPCNT_EN to also check oDropCnt.
// ---------------------------------------------------------------------------
module tb_page_fetch_arbiter;

    localparam int Y_W        = 10;
    localparam int LINE_SHIFT = 9;
    localparam int ADDR_W     = 24;
    localparam int QDEPTH     = 4;

    logic              iClock = 1'b0;
    logic              RESET  = 1'b0;
    logic [Y_W:0]      iTag   = '0;
    logic [1:0]        iCall  = 2'b00;
    logic [2:0]        iDone  = 3'b000;
    logic [1:0]        oDone;
    logic [2:0]        oCall;
    logic [ADDR_W-1:0] oAddrPage;
    logic              oOverflow;
    logic              oBusy;
`ifdef PAGE_FETCH_DROPCNT_EN
    logic [7:0]        oDropCnt;
`endif

    int total = 0;
    int bad   = 0;
    bit cmpEn = 1'b0;

    page_fetch_arbiter #(
        .Y_W(Y_W), .LINE_SHIFT(LINE_SHIFT), .ADDR_W(ADDR_W), .DEPTH_LOG2(2)
    ) dut (
        .iClock    (iClock),
        .RESET     (RESET),
        .iTag      (iTag),
        .iCall     (iCall),
        .oDone     (oDone),
        .oCall     (oCall),
        .iDone     (iDone),
        .oAddrPage (oAddrPage),
        .oOverflow (oOverflow),
`ifdef PAGE_FETCH_DROPCNT_EN
        .oDropCnt  (oDropCnt),
`endif
        .oBusy     (oBusy)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_PAGE, M_USER} modeT;
    modeT              mMode  = M_IDLE;
    logic [2:0]        mCall  = 3'b000;
    logic [ADDR_W-1:0] mAddr  = '0;
    bit                mOvf   = 1'b0;
    int                mDrops = 0;
    logic [Y_W:0]      mS1    = '0;
    logic [Y_W:0]      mS2    = '0;
    logic [Y_W-1:0]    mQ[$];

    always @(posedge iClock or negedge RESET) begin
        if (!RESET) begin
            mMode = M_IDLE; mCall = 3'b000; mAddr = '0; mOvf = 1'b0;
            mDrops = 0; mS1 = '0; mS2 = '0; mQ.delete();
        end else begin
            case (mMode)
                M_IDLE:
                    if (mQ.size() > 0) begin
                        mMode = M_PAGE; mCall = 3'b100;
                        mAddr = ADDR_W'(64'(mQ[0]) << LINE_SHIFT);
                    end else if (iCall != 2'b00) begin
                        mMode = M_USER;
                        mCall = iCall[1] ? 3'b010 : 3'b001;
                    end
                M_PAGE:
                    if (iDone[2]) begin
                        mMode = M_IDLE; mCall = 3'b000;
                        void'(mQ.pop_front());
                    end
                M_USER:
                    if ((iDone[1:0] & mCall[1:0]) != 2'b00) begin
                        mMode = M_IDLE; mCall = 3'b000;
                    end
                default: mMode = M_IDLE;
            endcase
            // Any pop has already been applied, so a full queue here means
            // the push really has no room.
            if (mS1[Y_W] && !mS2[Y_W]) begin
                if (mQ.size() >= QDEPTH) begin
                    mOvf = 1'b1;
                    mDrops++;
                end else begin
                    mQ.push_back(mS1[Y_W-1:0]);
                end
            end
            mS2 = mS1;
            mS1 = iTag;
        end
    end

    always @(negedge iClock) begin
        if (cmpEn) begin
            check("oCall", 32'(oCall), 32'(mCall));
            check("oAddrPage", 32'(oAddrPage), 32'(mAddr));
            check("oBusy", 32'(oBusy), 32'(mMode != M_IDLE));
            check("oOverflow", 32'(oOverflow), 32'(mOvf));
            check("oDone", 32'(oDone),
                  32'((mMode == M_USER) ? (iDone[1:0] & mCall[1:0]) : 2'b00));
`ifdef PAGE_FETCH_DROPCNT_EN
            check("oDropCnt", 32'(oDropCnt), 32'((mDrops > 255) ? 255 : mDrops));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic doReset();
        iTag = '0; iCall = 2'b00; iDone = 3'b000;
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
    endtask

    // Two cycles low then two high. The push lands on the last edge.
    task automatic tagEdge(input logic [Y_W-1:0] line);
        iTag = {1'b0, line}; tick(); tick();
        iTag = {1'b1, line}; tick(); tick();
    endtask

    logic [ADDR_W-1:0] expAddr [4];
    logic [1:0]        dn;

    initial begin
        doReset();
        cmpEn = 1'b1;

        // A: tag edge with line 37 leads to a page read at 37 << 9.
        iTag = {1'b0, 10'd37}; tick(); tick();
        iTag = {1'b1, 10'd37};
        for (int i = 0; i < 6; i++) begin
            tick();
            if (oCall == 3'b100) break;
        end
        check("A_call", 32'(oCall), 32'h4);
        check("A_addr", 32'(oAddrPage), 32'h004A00);
        iDone = 3'b100; tick(); iDone = 3'b000;
        check("A_clear", 32'(oCall), 32'h0);
        tick(); tick();
        check("A_empty", 32'(oCall), 32'h0);

        // B: both request bits set gives a write. A stray read-done is ignored.
        doReset();
        iCall = 2'b11; tick();
        check("B_call", 32'(oCall), 32'h2);
        iDone = 3'b001; #1;
        check("B_ignore", 32'(oDone), 32'h0);
        tick();
        check("B_hold", 32'(oCall), 32'h2);
        iDone = 3'b010; #1;
        check("B_done", 32'(oDone), 32'h2);
        tick(); iDone = 3'b000; iCall = 2'b00; #1;
        check("B_doneoff", 32'(oDone), 32'h0);
        check("B_idle", 32'(oBusy), 32'h0);

        // C: a tag edge during a user write waits for the write to finish.
        doReset();
        iCall = 2'b10; tick();
        tagEdge(10'd5);
        check("C_nopreempt", 32'(oCall), 32'h2);
        iDone = 3'b010; tick(); iDone = 3'b000; iCall = 2'b00;
        check("C_idlegap", 32'(oCall), 32'h0);
        tick();
        check("C_page", 32'(oCall), 32'h4);
        check("C_addr", 32'(oAddrPage), 32'h000A00);
        iDone = 3'b100; tick(); iDone = 3'b000;

        // D: five edges and no completion. Four are kept, one is dropped.
        doReset();
        for (int i = 1; i <= 4; i++) tagEdge(Y_W'(i));
        check("D_noovf", 32'(oOverflow), 32'h0);
        tagEdge(10'd5);
        check("D_ovf", 32'(oOverflow), 32'h1);
        check("D_addr", 32'(oAddrPage), 32'h000200);
`ifdef PAGE_FETCH_DROPCNT_EN
        check("D_dropcnt", 32'(oDropCnt), 32'h1);
`endif

        // E: FIFO full, and the page completes on the cycle of a new push.
        doReset();
        for (int i = 1; i <= 4; i++) tagEdge(Y_W'(i));
        iTag = {1'b0, 10'd9}; tick(); tick();
        iTag = {1'b1, 10'd9}; tick();
        iDone = 3'b100; tick(); iDone = 3'b000;
        check("E_noovf", 32'(oOverflow), 32'h0);
        expAddr[0] = 24'h000400; expAddr[1] = 24'h000600;
        expAddr[2] = 24'h000800; expAddr[3] = 24'h001200;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("E_order", 32'(oAddrPage), 32'(expAddr[i]));
            iDone = 3'b100; tick(); iDone = 3'b000;
        end
        tick(); tick();
        check("E_drained", 32'(oCall), 32'h0);

        // F: reset during a page read clears oCall at once and drops the queue.
        doReset();
        tagEdge(10'd3); tagEdge(10'd4);
        check("F_page", 32'(oCall), 32'h4);
        iTag = '0; RESET = 1'b0; #1;
        check("F_rstcall", 32'(oCall), 32'h0);
        check("F_rstbusy", 32'(oBusy), 32'h0);
        tick(); RESET = 1'b1;
        repeat (5) tick();
        check("F_lost", 32'(oCall), 32'h0);

        // Randomized phase. The model checks every cycle.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge iClock);
            dn = oDone;
            tick();
            RESET = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
            if (dn != 2'b00) iCall = 2'b00;
            else if (iCall == 2'b00 && $urandom_range(0, 7) == 0)
                iCall = 2'($urandom_range(1, 3));
            iDone = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            if ($urandom_range(0, 2) == 0)
                iTag = {1'($urandom_range(0, 1)), Y_W'($urandom)};
        end
        RESET = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
